// File: rtl/uart_tx_result_ctrl.sv
// Sends a 16-bit result to uart_basic as two bytes, low byte first, with a
// programmable settle delay before byte 0 and an idle gap between the bytes.
module uart_tx_result_ctrl #(
  parameter int INTER_BYTE_DELAY        = 1000000,
  parameter int WAIT_FOR_REGISTER_DELAY = 100,
  parameter int BUSY_TIMEOUT            = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [15:0] result,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  status
);

  // state    | meaning
  // IDLE     | waiting for trigger; result captured on acceptance
  // REG_WAIT | settle delay before the first byte
  // SEND_LSB | one-cycle tx_start with data_reg[7:0]
  // WAIT_LSB | wait for uart_basic to finish byte 0 (or busy timeout)
  // GAP      | inter-byte idle gap
  // SEND_MSB | one-cycle tx_start with data_reg[15:8]
  // WAIT_MSB | wait for uart_basic to finish byte 1 (or busy timeout)
  // DONE     | one-cycle done pulse

  localparam int MAX_AB = (INTER_BYTE_DELAY > WAIT_FOR_REGISTER_DELAY) ?
                          INTER_BYTE_DELAY : WAIT_FOR_REGISTER_DELAY;
  localparam int MAX_P  = (MAX_AB > BUSY_TIMEOUT) ? MAX_AB : BUSY_TIMEOUT;
  localparam int CW     = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);

  localparam bit REG_ZERO  = (WAIT_FOR_REGISTER_DELAY == 0);
  localparam bit GAP_ZERO  = (INTER_BYTE_DELAY == 0);
  localparam bit BT_ZERO   = (BUSY_TIMEOUT == 0);
  localparam logic [CW-1:0] REG_LAST = CW'(REG_ZERO ? 0 : WAIT_FOR_REGISTER_DELAY - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_ZERO ? 0 : INTER_BYTE_DELAY - 1);
  localparam logic [CW-1:0] BT_LAST  = CW'(BT_ZERO ? 0 : BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REG_WAIT = 3'd1,
    SEND_LSB = 3'd2,
    WAIT_LSB = 3'd3,
    GAP      = 3'd4,
    SEND_MSB = 3'd5,
    WAIT_MSB = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] counter_q, counter_d, counter_inc;
  logic          busy_seen_q, busy_seen_d;
  logic [15:0]   data_reg_q, data_reg_d;
  logic [7:0]    tx_data_q, tx_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      busy_seen_q <= 1'b0;
      data_reg_q  <= 16'h0000;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      busy_seen_q <= busy_seen_d;
      data_reg_q  <= data_reg_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // Saturating increment so a long busy phase can never wrap the counter.
  assign counter_inc = (counter_q == CNT_MAX) ? counter_q : counter_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    busy_seen_d = busy_seen_q;
    data_reg_d  = data_reg_q;
    tx_data_d   = tx_data_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          data_reg_d = result;
          counter_d  = '0;
          state_d    = REG_WAIT;
        end
      end
      REG_WAIT: begin
        // tx_data is loaded on entry so it is stable throughout the SEND cycle.
        if (REG_ZERO || counter_q == REG_LAST) begin
          tx_data_d = data_reg_q[7:0];
          state_d   = SEND_LSB;
        end else begin
          counter_d = counter_inc;
        end
      end
      SEND_LSB: begin
        counter_d   = '0;
        busy_seen_d = 1'b0;
        state_d     = WAIT_LSB;
      end
      WAIT_LSB, WAIT_MSB: begin
        counter_d = counter_inc;
        if (tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q || BT_ZERO || counter_q == BT_LAST) begin
          counter_d = '0;
          state_d   = (state_q == WAIT_LSB) ? GAP : DONE;
        end
      end
      GAP: begin
        if (GAP_ZERO || counter_q == GAP_LAST) begin
          tx_data_d = data_reg_q[15:8];
          state_d   = SEND_MSB;
        end else begin
          counter_d = counter_inc;
        end
      end
      SEND_MSB: begin
        counter_d   = '0;
        busy_seen_d = 1'b0;
        state_d     = WAIT_MSB;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == SEND_LSB) || (state_q == SEND_MSB);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign status   = {1'b0, state_q};

endmodule
